// File: rtl/spi_master_if.sv
// ============================================================================
// Module      : spi_master_if
// Description : Byte request/response and serial-line bundle for spi_master.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface spi_master_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       hold_cs;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       busy;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       miso;

    modport master (
        input  data_in, data_in_valid, hold_cs, miso,
        output data_out, data_out_valid, busy, sck, cs, mosi
    );

    modport slave (
        output data_in, data_in_valid, hold_cs, miso,
        input  data_out, data_out_valid, busy, sck, cs, mosi
    );
endinterface

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module      : spi_master
// Description : Byte-oriented SPI master with optional multi-byte frames.
//               Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_master #(
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0
) (
    input  wire logic      clk,
    input  wire logic      reset,
    spi_master_if.master   bus
);

    localparam int               c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_XFER  = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_GAP   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_DIV_W-1:0] r_div;
    logic [3:0]         r_edge;
    logic [7:0]         r_tx;
    logic [7:0]         r_rx;
    logic [7:0]         r_data_out;
    logic               r_dov;
    logic               r_sck;
    logic               r_mosi;
    logic               r_cs;
    logic               r_busy;
    logic               w_cs_next;
    logic               w_busy_next;
    logic               w_active;
    logic               w_tick;
    logic               w_accept;
    logic               w_last_edge;
    logic               w_sample;
    logic [7:0]         w_rx_in;
    logic [7:0]         w_rx_next;

    function automatic logic f_first(input logic [7:0] v);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return v[0];
`else
        return v[7];
`endif
    endfunction

    function automatic logic [7:0] f_shift(input logic [7:0] v);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return {1'b0, v[7:1]};
`else
        return {v[6:0], 1'b0};
`endif
    endfunction

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign w_rx_in = {bus.miso, r_rx[7:1]};
`else
    assign w_rx_in = {r_rx[6:0], bus.miso};
`endif

    assign w_active    = (r_state == c_SETUP) || (r_state == c_XFER) || (r_state == c_GAP);
    assign w_tick      = w_active && (r_div == c_DIV_LAST);
    assign w_accept    = bus.data_in_valid && ((r_state == c_IDLE) || (r_state == c_WAIT));
    assign w_last_edge = (r_state == c_XFER) && w_tick && (r_edge == 4'd15);
    // Even edges are leading; CPHA selects which parity samples miso.
    assign w_sample    = (r_edge[0] == CPHA);
    assign w_rx_next   = w_sample ? w_rx_in : r_rx;

    // State register; cs/busy are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cs    <= w_cs_next;
            r_busy  <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_next = c_SETUP;
            c_SETUP: if (w_tick) w_state_next = c_XFER;
            c_XFER:  if (w_last_edge) w_state_next = bus.hold_cs ? c_WAIT : c_GAP;
            c_WAIT: begin
                if (w_accept)          w_state_next = c_SETUP;
                else if (!bus.hold_cs) w_state_next = c_GAP;
            end
            c_GAP:   if (w_tick) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_cs_next   = !((w_state_next == c_SETUP) || (w_state_next == c_XFER) ||
                        (w_state_next == c_WAIT));
        w_busy_next = (w_state_next == c_SETUP) || (w_state_next == c_XFER) ||
                      (w_state_next == c_GAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div      <= '0;
            r_edge     <= 4'd0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_data_out <= 8'h00;
            r_dov      <= 1'b0;
            r_sck      <= CPOL;
            r_mosi     <= 1'b0;
        end else begin
            r_dov <= w_last_edge;
            r_div <= (w_active && !w_tick) ? r_div + c_DIV_ONE : '0;
            if (w_accept) begin
                r_tx   <= bus.data_in;
                r_edge <= 4'd0;
                if (!CPHA) r_mosi <= f_first(bus.data_in);
            end
            if ((r_state == c_XFER) && w_tick) begin
                r_sck  <= ~r_sck;
                r_edge <= r_edge + 4'd1;
                r_rx   <= w_rx_next;
                if (w_last_edge) r_data_out <= w_rx_next;
                if (!CPHA) begin
                    // The first bit is already on mosi, so the 16th edge shifts nothing.
                    if (r_edge[0] && !w_last_edge) begin
                        r_tx   <= f_shift(r_tx);
                        r_mosi <= f_first(f_shift(r_tx));
                    end
                end else if (!r_edge[0]) begin
                    r_mosi <= f_first(r_tx);
                    r_tx   <= f_shift(r_tx);
                end
            end
        end
    end

    assign bus.sck            = r_sck;
    assign bus.cs             = r_cs;
    assign bus.busy           = r_busy;
    assign bus.mosi           = r_mosi;
    assign bus.data_out       = r_data_out;
    assign bus.data_out_valid = r_dov;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module      : tb_spi_master
// Description : Directed bench for spi_master: mode 0 / CLK_DIV=2 and
//               CPOL=1,CPHA=1 / CLK_DIV=1 instances side by side.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_master;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_if a_if ();
    spi_master_if b_if ();

    spi_master #(.CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u_a (
        .clk(clk), .reset(reset), .bus(a_if.master));
    spi_master #(.CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1)) u_b (
        .clk(clk), .reset(reset), .bus(b_if.master));

    logic       a_loop = 1'b0;
    logic       a_sl_bit = 1'b0;
    logic [7:0] sl_pat = 8'h3C;
    assign a_if.miso = a_loop ? a_if.mosi : a_sl_bit;
    assign b_if.miso = b_if.mosi;

    int n_cmp = 0, n_fail = 0;
    int a_rises = 0, a_busy_cyc = 0, a_cslow_cyc = 0, a_dov_cnt = 0;
    int a_cs_rises = 0, a_cs_rise_idle = 0, sl_idx = 0;
    int b_busy_cyc = 0, b_dov_cnt = 0;
    logic [15:0] a_mosi_hist = 16'h0000;
    logic a_prev_sck = 1'b0, a_prev_cs = 1'b0;
    int s_rises, s_busy, s_cslow, s_dov, s_csr, s_csri;

    // Line monitor plus a mode-0 slave that shifts sl_pat out MSB first.
    always @(negedge clk) begin
        if (a_if.sck && !a_prev_sck) begin
            a_rises++;
            a_mosi_hist = {a_mosi_hist[14:0], a_if.mosi};
        end
        if (a_if.busy) a_busy_cyc++;
        if (!a_if.cs) a_cslow_cyc++;
        if (a_if.data_out_valid) a_dov_cnt++;
        if (a_if.cs && !a_prev_cs) begin
            a_cs_rises++;
            if (!a_if.busy) a_cs_rise_idle++;
        end
        if (a_if.cs) sl_idx = 0;
        else if (!a_if.sck && a_prev_sck && sl_idx < 7) sl_idx++;
        a_sl_bit = sl_pat[7-sl_idx];
        a_prev_sck = a_if.sck;
        a_prev_cs  = a_if.cs;
        if (b_if.busy) b_busy_cyc++;
        if (b_if.data_out_valid) b_dov_cnt++;
    end

    function automatic logic [7:0] exp_wire(input logic [7:0] v);
        logic [7:0] r;
        r = v;
`ifdef SPI_MASTER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
`endif
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_rises = a_rises; s_busy = a_busy_cyc; s_cslow = a_cslow_cyc;
        s_dov = a_dov_cnt; s_csr = a_cs_rises; s_csri = a_cs_rise_idle;
    endtask

    task automatic send_a(input logic [7:0] v, input logic h);
        a_if.data_in = v; a_if.data_in_valid = 1'b1; a_if.hold_cs = h;
        step();
        a_if.data_in_valid = 1'b0;
        a_if.data_in = 8'hEE;
    endtask

    task automatic wait_a_idle(input string tag);
        int k = 0;
        while (a_if.busy && k < 400) begin step(); k++; end
        check({tag, " idle timeout"}, 16'(a_if.busy), 16'(0));
    endtask

    task automatic wait_a_dov(input int target, input string tag);
        int k = 0;
        while (a_dov_cnt < target && k < 400) begin step(); k++; end
        check({tag, " dov timeout"}, 16'(a_dov_cnt), 16'(target));
    endtask

    initial begin
        reset = 1'b1;
        a_if.data_in = 8'h00; a_if.data_in_valid = 1'b0; a_if.hold_cs = 1'b0;
        b_if.data_in = 8'h00; b_if.data_in_valid = 1'b0; b_if.hold_cs = 1'b0;
        repeat (3) step();
        check("rst a cs",   16'(a_if.cs), 16'(1));
        check("rst a sck",  16'(a_if.sck), 16'(0));
        check("rst a mosi", 16'(a_if.mosi), 16'(0));
        check("rst a busy", 16'(a_if.busy), 16'(0));
        check("rst a dout", 16'(a_if.data_out), 16'(0));
        check("rst a dov",  16'(a_if.data_out_valid), 16'(0));
        check("rst b sck",  16'(b_if.sck), 16'(1));
        check("rst b cs",   16'(b_if.cs), 16'(1));
        reset = 1'b0;
        step();

        // Mode 0, 0xA5 out, slave returns 0x3C
        snap();
        send_a(8'hA5, 1'b0);
        wait_a_idle("a5");
        check("a5 mosi",  16'(a_mosi_hist[7:0]), 16'(exp_wire(8'hA5)));
        check("a5 dout",  16'(a_if.data_out), 16'(exp_wire(8'h3C)));
        check("a5 dov",   16'(a_dov_cnt - s_dov), 16'(1));
        check("a5 rises", 16'(a_rises - s_rises), 16'(8));
        check("a5 busy",  16'(a_busy_cyc - s_busy), 16'(36));
        check("a5 cslow", 16'(a_cslow_cyc - s_cslow), 16'(34));

        // Request while busy is dropped
        snap();
        send_a(8'h55, 1'b0);
        repeat (10) step();
        a_if.data_in = 8'hFF; a_if.data_in_valid = 1'b1;
        step();
        a_if.data_in_valid = 1'b0;
        wait_a_idle("ign");
        repeat (10) step();
        check("ign busy",  16'(a_if.busy), 16'(0));
        check("ign mosi",  16'(a_mosi_hist[7:0]), 16'(exp_wire(8'h55)));
        check("ign rises", 16'(a_rises - s_rises), 16'(8));
        check("ign busyc", 16'(a_busy_cyc - s_busy), 16'(36));
        check("ign dov",   16'(a_dov_cnt - s_dov), 16'(1));

        // Two-byte frame through WAIT
        a_loop = 1'b1;
        snap();
        send_a(8'h12, 1'b1);
        wait_a_dov(s_dov + 1, "hold1");
        check("hold1 busy", 16'(a_if.busy), 16'(0));
        check("hold1 cs",   16'(a_if.cs), 16'(0));
        check("hold1 dout", 16'(a_if.data_out), 16'(8'h12));
        send_a(8'h34, 1'b1);
        wait_a_dov(s_dov + 2, "hold2");
        check("hold2 dout", 16'(a_if.data_out), 16'(8'h34));
        a_if.hold_cs = 1'b0;
        repeat (6) step();
        check("hold end cs",    16'(a_if.cs), 16'(1));
        check("hold end busy",  16'(a_if.busy), 16'(0));
        check("hold cs rises",  16'(a_cs_rises - s_csr), 16'(1));
        check("hold cs idle",   16'(a_cs_rise_idle - s_csri), 16'(0));
        check("hold dov",       16'(a_dov_cnt - s_dov), 16'(2));
        check("hold mosi",      a_mosi_hist, {exp_wire(8'h12), exp_wire(8'h34)});

        // Reset during edge 7
        snap();
        send_a(8'h5A, 1'b0);
        begin
            int k = 0;
            while (a_rises < s_rises + 4 && k < 400) begin step(); k++; end
        end
        check("mid rises", 16'(a_rises - s_rises), 16'(4));
        reset = 1'b1;
        step();
        check("mid cs",   16'(a_if.cs), 16'(1));
        check("mid sck",  16'(a_if.sck), 16'(0));
        check("mid busy", 16'(a_if.busy), 16'(0));
        check("mid dout", 16'(a_if.data_out), 16'(0));
        check("mid dov",  16'(a_if.data_out_valid), 16'(0));
        reset = 1'b0;
        repeat (40) step();
        check("mid no dov", 16'(a_dov_cnt - s_dov), 16'(0));

        snap();
        send_a(8'hC3, 1'b0);
        wait_a_idle("c3");
        check("c3 dout", 16'(a_if.data_out), 16'(8'hC3));
        check("c3 busy", 16'(a_busy_cyc - s_busy), 16'(36));
        check("c3 dov",  16'(a_dov_cnt - s_dov), 16'(1));

        snap();
        send_a(8'h01, 1'b0);
        wait_a_idle("b01");
        check("b01 mosi", 16'(a_mosi_hist[7:0]), 16'(exp_wire(8'h01)));
        check("b01 dout", 16'(a_if.data_out), 16'(8'h01));

        // CPOL=1, CPHA=1, CLK_DIV=1 loopback
        s_busy = b_busy_cyc; s_dov = b_dov_cnt;
        b_if.data_in = 8'h81; b_if.data_in_valid = 1'b1;
        step();
        b_if.data_in_valid = 1'b0;
        begin
            int k = 0;
            while (b_if.busy && k < 200) begin step(); k++; end
        end
        check("b idle",  16'(b_if.busy), 16'(0));
        check("b dout",  16'(b_if.data_out), 16'(8'h81));
        check("b busy",  16'(b_busy_cyc - s_busy), 16'(18));
        check("b dov",   16'(b_dov_cnt - s_dov), 16'(1));
        check("b sck",   16'(b_if.sck), 16'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
